// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and instruction register for the MIPS front end, with redirect and end-of-program detection.
module fetch_unit #(
  parameter int unsigned PROG_BYTES = 80,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  output logic [31:0] imem_addr,
  output logic        imem_start,
  input  logic [31:0] imem_instruction,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic        in_range, fire, fetch_en;
  assign in_range   = pc_q < 32'(PROG_BYTES);
  assign fire       = ir_valid_q && ir_ready;
  assign fetch_en   = in_range && (!ir_valid_q || ir_ready);
  assign imem_addr  = pc_q;
  assign imem_start = state_q == LOAD;
  assign done       = state_q == DONE;
  assign ir         = ir_q;
  assign ir_pc      = ir_pc_q;
  assign ir_valid   = ir_valid_q;
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    case (state_q)
      IDLE: begin
        pc_d       = RESET_PC;
        ir_valid_d = 1'b0;
        state_d    = go ? LOAD : IDLE;
      end
      LOAD: state_d = RUN;
      RUN: begin
        // a redirect flushes the held beat and suppresses capture on this edge
        if (redirect) begin
          pc_d       = {redirect_pc[31:2], 2'b00};
          ir_valid_d = 1'b0;
        end else begin
          if (fetch_en) begin
            ir_d       = imem_instruction;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
          end else if (fire) begin
            ir_valid_d = 1'b0;
          end
          if (!in_range && (!ir_valid_q || fire)) state_d = DONE;
        end
      end
      DONE: begin
        ir_valid_d = 1'b0;
        pc_d       = go ? RESET_PC : pc_q;
        state_d    = go ? LOAD : DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test-plan scenarios plus random traffic against a behavioural model of the fetch stage.
module tb_fetch_unit;
  localparam int unsigned P = 80;
  logic        clk = 0, reset, go, imem_start, ir_valid, ir_ready, redirect, done;
  logic [31:0] imem_addr, imem_instruction, ir, ir_pc, redirect_pc;
  int          n_cmp = 0, n_err = 0;
  int          ph;
  logic [31:0] m_pc, m_ir, m_irpc;
  bit          m_v;
  bit          used, hold, rd, rs, g;
  int          bp;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  assign imem_instruction = mem_word(imem_addr);

  fetch_unit #(.PROG_BYTES(P), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .go(go), .imem_addr(imem_addr), .imem_start(imem_start),
    .imem_instruction(imem_instruction), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .redirect(redirect), .redirect_pc(redirect_pc), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // phases: 0 idle, 1 load, 2 run, 3 done
  task automatic model_step();
    bit fire, last;
    if (reset) begin
      ph = 0; m_pc = 0; m_v = 0; m_ir = 0; m_irpc = 0;
      return;
    end
    case (ph)
      0: begin m_pc = 0; if (go) ph = 1; end
      1: ph = 2;
      2: begin
        fire = m_v && ir_ready;
        last = m_pc >= P && (!m_v || fire);
        if (redirect) begin
          m_pc = redirect_pc & ~32'h3;
          m_v = 0;
        end else begin
          if (m_pc < P && (!m_v || ir_ready)) begin
            m_ir = mem_word(m_pc); m_irpc = m_pc; m_v = 1; m_pc = m_pc + 4;
          end else if (fire) m_v = 0;
          if (last) begin ph = 3; m_v = 0; end
        end
      end
      default: begin m_v = 0; if (go) begin m_pc = 0; ph = 1; end end
    endcase
  endtask

  task automatic step(input bit g_i, input bit r_i, input bit rd_i, input logic [31:0] rpc_i, input bit rs_i);
    go = g_i; ir_ready = r_i; redirect = rd_i; redirect_pc = rpc_i; reset = rs_i;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("imem_addr", imem_addr, m_pc);
    chk("imem_start", 32'(imem_start), 32'(ph == 1));
    chk("done", 32'(done), 32'(ph == 3));
    chk("ir_valid", 32'(ir_valid), 32'(m_v));
    chk("ir_pc", ir_pc, m_irpc);
    chk("ir", ir, m_ir);
    if (ir_valid) chk("ir_matches_mem", ir, mem_word(ir_pc));
  endtask

  initial begin
    go = 0; ir_ready = 1; redirect = 0; redirect_pc = 0; reset = 1;
    ph = 0; m_pc = 0; m_ir = 0; m_irpc = 0; m_v = 0;
    @(negedge clk);
    repeat (2) step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    // straight line to done
    step(1, 1, 0, 0, 0);
    repeat (28) step(0, 1, 0, 0, 0);
    // backpressure at 0x08, then redirect to 0x22 while 0x0C is held
    step(1, 1, 0, 0, 0);
    bp = 0; used = 0;
    repeat (40) begin
      hold = m_v && m_irpc == 32'h8 && bp < 3;
      if (hold) bp++;
      rd = m_v && m_irpc == 32'hC && !used;
      if (rd) used = 1;
      step(0, !hold, rd, 32'h22, 0);
    end
    // redirect out of range
    step(1, 1, 0, 0, 0);
    used = 0;
    repeat (20) begin
      rd = m_v && m_irpc == 32'h10 && !used;
      if (rd) used = 1;
      step(0, 1, rd, 32'h50, 0);
    end
    // go during RUN ignored, reset mid-run, then replay
    step(1, 1, 0, 0, 0);
    used = 0;
    repeat (15) begin
      rs = m_v && m_irpc == 32'h18 && !used;
      if (rs) used = 1;
      g = m_v && m_irpc == 32'h4;
      step(g, 1, 0, 0, rs);
    end
    step(1, 1, 0, 0, 0);
    repeat (30) step(0, 1, 0, 0, 0);
    // random traffic
    repeat (2000) begin
      g  = ($urandom % 16) == 0;
      rd = ($urandom % 12) == 0;
      rs = ($urandom % 200) == 0;
      step(g, ($urandom % 4) != 0, rd, $urandom_range(0, 32'h60), rs);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
